// File: rtl/rr_onehot_grant_sched.sv
// Round-robin scheduler granting one of 2^N requesters with a registered one-hot grant.
// Optional hold-limit revoke is built when GRANT_TIMEOUT_EN is defined.
module rr_onehot_grant_sched #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [(1<<N)-1:0]  req_i,
    input  logic               release_i,
    output logic [(1<<N)-1:0]  grant_o,
    output logic [N-1:0]       grant_idx_o,
    output logic               grant_valid_o,
    output logic               timeout_pulse_o,
    output logic               dbg_state_o
);
    localparam int R = 1 << N;

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    // Handshake: req_i is a level held by each requester; release_i is only
    // meaningful while grant_valid_o is high and ends ownership at the next edge.
    state_t         state_q;
    logic [N-1:0]   ptr_q;
    logic [N-1:0]   idx_q;
    logic [R-1:0]   grant_q;
    logic           valid_q;
    logic           timeout_q;
    logic [N-1:0]   winner_d;
    logic           found_d;
    logic [N-1:0]   scan_idx;
    logic           exit_d;
    logic [R-1:0]   one_hot_base;

`ifdef GRANT_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    logic [HOLD_W-1:0] hold_q;
`endif

    assign one_hot_base = {{(R-1){1'b0}}, 1'b1};

    // Scan from ptr_q upward with wraparound; first set bit wins.
    always_comb begin
        found_d  = 1'b0;
        winner_d = '0;
        scan_idx = '0;
        for (int i = 0; i < R; i++) begin
            scan_idx = ptr_q + N'(i);
            if (!found_d && req_i[scan_idx]) begin
                found_d  = 1'b1;
                winner_d = scan_idx;
            end
        end
    end

    assign exit_d = release_i || !req_i[idx_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
            hold_q    <= '0;
`endif
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q <= OWN;
                        idx_q   <= winner_d;
                        grant_q <= one_hot_base << winner_d;
                        valid_q <= 1'b1;
`ifdef GRANT_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end
                end
                OWN: begin
                    if (exit_d) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        valid_q <= 1'b0;
                        ptr_q   <= idx_q + 1'b1;
`ifdef GRANT_TIMEOUT_EN
                    end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                        // Forced revoke; a normal exit in the same cycle wins above.
                        state_q   <= IDLE;
                        grant_q   <= '0;
                        valid_q   <= 1'b0;
                        ptr_q     <= idx_q + 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o         = grant_q;
    assign grant_idx_o     = idx_q;
    assign grant_valid_o   = valid_q;
    assign timeout_pulse_o = timeout_q;
    assign dbg_state_o     = state_q;
endmodule
